// File: rtl/i3c_csr_pkg.sv
// Shared widths, register offsets, field masks and hardware-interface structs
// for the I3C host-controller CSR block.
package I3CCSR_pkg;

  localparam int I3CCSR_DATA_WIDTH     = 32;
  localparam int I3CCSR_MIN_ADDR_WIDTH = 8;

  localparam logic [7:0] ADDR_HC_VERSION             = 8'h00;
  localparam logic [7:0] ADDR_HC_CONTROL             = 8'h04;
  localparam logic [7:0] ADDR_CONTROLLER_DEVICE_ADDR = 8'h08;
  localparam logic [7:0] ADDR_HC_CAPABILITIES        = 8'h0C;
  localparam logic [7:0] ADDR_RESET_CONTROL          = 8'h10;
  localparam logic [7:0] ADDR_PRESENT_STATE          = 8'h14;
  localparam logic [7:0] ADDR_INTR_STATUS            = 8'h20;
  localparam logic [7:0] ADDR_INTR_STATUS_ENABLE     = 8'h24;
  localparam logic [7:0] ADDR_INTR_SIGNAL_ENABLE     = 8'h28;
  localparam logic [7:0] ADDR_INTR_FORCE             = 8'h2C;

  localparam logic [31:0] HC_VERSION_VAL          = 32'h0000_0120;
  localparam logic [31:0] HC_CONTROL_MASK         = 32'hE000_0001;
  localparam logic [31:0] CTRL_DEV_ADDR_MASK      = 32'h807F_0000;
  localparam logic [31:0] RESET_CONTROL_MASK      = 32'h0000_003F;

  typedef enum logic [3:0] {
    REG_HC_VERSION,
    REG_HC_CONTROL,
    REG_CTRL_DEV_ADDR,
    REG_HC_CAPABILITIES,
    REG_RESET_CONTROL,
    REG_PRESENT_STATE,
    REG_INTR_STATUS,
    REG_INTR_STATUS_EN,
    REG_INTR_SIGNAL_EN,
    REG_INTR_FORCE,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    logic [31:0] hc_capabilities;
    logic [31:0] present_state;
    logic        soft_rst_clr;
    logic [31:0] intr_set;
  } I3CCSR__in_t;

  typedef struct packed {
    logic [31:0] hc_control;
    logic [31:0] controller_device_addr;
    logic [31:0] reset_control;
    logic [31:0] intr_status;
    logic [31:0] intr_status_en;
    logic [31:0] intr_signal_en;
    logic        intr;
  } I3CCSR__out_t;

  function automatic logic [31:0] apply_biten(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] biten);
    return (old_val & ~biten) | (wdata & biten);
  endfunction

endpackage

// File: rtl/i3c_csr.sv
// I3C host-controller CSR block: zero-latency CPU interface, RW/RO/W1C
// registers and a level interrupt output built from status and signal enables.
module i3c_csr
  import I3CCSR_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_cpuif_req,
  input  logic                              s_cpuif_req_is_wr,
  input  logic [I3CCSR_MIN_ADDR_WIDTH-1:0]  s_cpuif_addr,
  input  logic [I3CCSR_DATA_WIDTH-1:0]      s_cpuif_wr_data,
  input  logic [I3CCSR_DATA_WIDTH-1:0]      s_cpuif_wr_biten,
  output logic                              s_cpuif_req_stall_wr,
  output logic                              s_cpuif_req_stall_rd,
  output logic                              s_cpuif_rd_ack,
  output logic                              s_cpuif_rd_err,
  output logic [I3CCSR_DATA_WIDTH-1:0]      s_cpuif_rd_data,
  output logic                              s_cpuif_wr_ack,
  output logic                              s_cpuif_wr_err,
  input  I3CCSR__in_t                       hwif_in,
  output I3CCSR__out_t                      hwif_out
);

  logic        rd_req;
  logic        wr_req;
  reg_sel_e    sel;
  logic [7:0]  word_addr;

  logic [31:0] hc_control_q,     hc_control_d;
  logic [31:0] ctrl_dev_addr_q,  ctrl_dev_addr_d;
  logic [31:0] reset_control_q,  reset_control_d;
  logic [31:0] intr_status_q,    intr_status_d;
  logic [31:0] intr_status_en_q, intr_status_en_d;
  logic [31:0] intr_signal_en_q, intr_signal_en_d;

  logic [31:0] wr_bits;
  logic [31:0] w1c_clr;
  logic [31:0] force_set;

  assign rd_req    = s_cpuif_req & ~s_cpuif_req_is_wr;
  assign wr_req    = s_cpuif_req &  s_cpuif_req_is_wr;
  assign word_addr = {s_cpuif_addr[7:2], 2'b00};
  assign wr_bits   = s_cpuif_wr_data & s_cpuif_wr_biten;

  // Address decode
  always_comb begin
    sel = REG_NONE;
    case (word_addr)
      ADDR_HC_VERSION:             sel = REG_HC_VERSION;
      ADDR_HC_CONTROL:             sel = REG_HC_CONTROL;
      ADDR_CONTROLLER_DEVICE_ADDR: sel = REG_CTRL_DEV_ADDR;
      ADDR_HC_CAPABILITIES:        sel = REG_HC_CAPABILITIES;
      ADDR_RESET_CONTROL:          sel = REG_RESET_CONTROL;
      ADDR_PRESENT_STATE:          sel = REG_PRESENT_STATE;
      ADDR_INTR_STATUS:            sel = REG_INTR_STATUS;
      ADDR_INTR_STATUS_ENABLE:     sel = REG_INTR_STATUS_EN;
      ADDR_INTR_SIGNAL_ENABLE:     sel = REG_INTR_SIGNAL_EN;
      ADDR_INTR_FORCE:             sel = REG_INTR_FORCE;
      default:                     sel = REG_NONE;
    endcase
  end

  // Next-state write logic
  always_comb begin
    // NOTE: every next-state value defaults to its current register so no path leaves it unassigned (no latch).
    hc_control_d     = hc_control_q;
    ctrl_dev_addr_d  = ctrl_dev_addr_q;
    reset_control_d  = reset_control_q;
    intr_status_en_d = intr_status_en_q;
    intr_signal_en_d = intr_signal_en_q;
    w1c_clr          = '0;
    force_set        = '0;

    if (wr_req) begin
      case (sel)
        REG_HC_CONTROL:
          hc_control_d = apply_biten(hc_control_q, s_cpuif_wr_data, s_cpuif_wr_biten) & HC_CONTROL_MASK;
        REG_CTRL_DEV_ADDR:
          ctrl_dev_addr_d = apply_biten(ctrl_dev_addr_q, s_cpuif_wr_data, s_cpuif_wr_biten) & CTRL_DEV_ADDR_MASK;
        REG_RESET_CONTROL:
          reset_control_d = apply_biten(reset_control_q, s_cpuif_wr_data, s_cpuif_wr_biten) & RESET_CONTROL_MASK;
        REG_INTR_STATUS_EN:
          intr_status_en_d = apply_biten(intr_status_en_q, s_cpuif_wr_data, s_cpuif_wr_biten);
        REG_INTR_SIGNAL_EN:
          intr_signal_en_d = apply_biten(intr_signal_en_q, s_cpuif_wr_data, s_cpuif_wr_biten);
        REG_INTR_STATUS: w1c_clr   = wr_bits;
        REG_INTR_FORCE:  force_set = wr_bits;
        default: ;
      endcase
    end

    // Hardware self-clear of the soft-reset bit overrides software.
    if (hwif_in.soft_rst_clr) reset_control_d[0] = 1'b0;

    // Set is OR'ed in after the clear so a same-cycle set wins.
    intr_status_d = (intr_status_q & ~w1c_clr) |
                    ((hwif_in.intr_set | force_set) & intr_status_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_control_q     <= '0;
      ctrl_dev_addr_q  <= '0;
      reset_control_q  <= '0;
      intr_status_q    <= '0;
      intr_status_en_q <= '0;
      intr_signal_en_q <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      hc_control_q     <= hc_control_d;
      ctrl_dev_addr_q  <= ctrl_dev_addr_d;
      reset_control_q  <= reset_control_d;
      intr_status_q    <= intr_status_d;
      intr_status_en_q <= intr_status_en_d;
      intr_signal_en_q <= intr_signal_en_d;
    end
  end

  // Readback mux; hardware-sourced RO values are masked while in reset.
  always_comb begin
    s_cpuif_rd_data = '0;
    if (rd_req) begin
      case (sel)
        REG_HC_VERSION:      s_cpuif_rd_data = HC_VERSION_VAL;
        REG_HC_CONTROL:      s_cpuif_rd_data = hc_control_q;
        REG_CTRL_DEV_ADDR:   s_cpuif_rd_data = ctrl_dev_addr_q;
        REG_HC_CAPABILITIES: s_cpuif_rd_data = rst ? '0 : hwif_in.hc_capabilities;
        REG_RESET_CONTROL:   s_cpuif_rd_data = reset_control_q;
        REG_PRESENT_STATE:   s_cpuif_rd_data = rst ? '0 : hwif_in.present_state;
        REG_INTR_STATUS:     s_cpuif_rd_data = intr_status_q;
        REG_INTR_STATUS_EN:  s_cpuif_rd_data = intr_status_en_q;
        REG_INTR_SIGNAL_EN:  s_cpuif_rd_data = intr_signal_en_q;
        default:             s_cpuif_rd_data = '0;
      endcase
    end
  end

  assign s_cpuif_req_stall_wr = 1'b0;
  assign s_cpuif_req_stall_rd = 1'b0;
  assign s_cpuif_rd_ack       = rd_req;
  assign s_cpuif_wr_ack       = wr_req;
  assign s_cpuif_rd_err       = rd_req & (sel == REG_NONE) & ~rst;
  assign s_cpuif_wr_err       = wr_req & (sel == REG_NONE) & ~rst;

  assign hwif_out.hc_control             = hc_control_q;
  assign hwif_out.controller_device_addr = ctrl_dev_addr_q;
  assign hwif_out.reset_control          = reset_control_q;
  assign hwif_out.intr_status            = intr_status_q;
  assign hwif_out.intr_status_en         = intr_status_en_q;
  assign hwif_out.intr_signal_en         = intr_signal_en_q;
  assign hwif_out.intr                   = |(intr_status_q & intr_signal_en_q);

endmodule

// File: tb/tb_i3c_csr.sv
// Directed scoreboard bench for i3c_csr: expected responses are queued when a
// request is driven and popped when the combinational response is sampled.
module tb_i3c_csr;
  import I3CCSR_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         is_wr;
  logic [7:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  biten;
  logic         stall_wr, stall_rd;
  logic         rd_ack, rd_err, wr_ack, wr_err;
  logic [31:0]  rd_data;
  I3CCSR__in_t  hwif_in;
  I3CCSR__out_t hwif_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        is_wr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  i3c_csr dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_cpuif_req          (req),
    .s_cpuif_req_is_wr    (is_wr),
    .s_cpuif_addr         (addr),
    .s_cpuif_wr_data      (wdata),
    .s_cpuif_wr_biten     (biten),
    .s_cpuif_req_stall_wr (stall_wr),
    .s_cpuif_req_stall_rd (stall_rd),
    .s_cpuif_rd_ack       (rd_ack),
    .s_cpuif_rd_err       (rd_err),
    .s_cpuif_rd_data      (rd_data),
    .s_cpuif_wr_ack       (wr_ack),
    .s_cpuif_wr_err       (wr_err),
    .hwif_in              (hwif_in),
    .hwif_out             (hwif_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the head of the scoreboard against the live response.
  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_wr) begin
      check({e.tag, "_wr_ack"}, {31'd0, wr_ack}, 32'd1);
      check({e.tag, "_wr_err"}, {31'd0, wr_err}, {31'd0, e.err});
      check({e.tag, "_rd_data_idle"}, rd_data, 32'd0);
    end else begin
      check({e.tag, "_rd_ack"}, {31'd0, rd_ack}, 32'd1);
      check({e.tag, "_rd_err"}, {31'd0, rd_err}, {31'd0, e.err});
      check({e.tag, "_rd_data"}, rd_data, e.data);
    end
  endtask

  // Both access tasks start just after a rising edge and return just after the next one.
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
    exp_q.push_back('{tag, 1'b0, exp, exp_err});
    req = 1'b1; is_wr = 1'b0; addr = a; wdata = '0; biten = '0;
    @(negedge clk);
    score();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic [31:0] be, input logic exp_err);
    exp_q.push_back('{tag, 1'b1, 32'd0, exp_err});
    req = 1'b1; is_wr = 1'b1; addr = a; wdata = d; biten = be;
    @(negedge clk);
    score();
    @(posedge clk); #1;
    req = 1'b0; is_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; is_wr = 1'b0; addr = '0; wdata = '0; biten = '0;
    hwif_in = '0;
    hwif_in.hc_capabilities = 32'hA5A5_0F0F;
    hwif_in.present_state   = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    check("reset_intr", {31'd0, hwif_out.intr}, 32'd0);
    check("reset_hc_control_out", hwif_out.hc_control, 32'd0);
    check("reset_stall", {30'd0, stall_wr, stall_rd}, 32'd0);
    rd("reset_rd_version", ADDR_HC_VERSION, HC_VERSION_VAL, 1'b0);
    rd("reset_rd_caps_masked", ADDR_HC_CAPABILITIES, 32'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    rd("rd_version", ADDR_HC_VERSION, 32'h0000_0120, 1'b0);
    rd("rd_hc_control_rst", ADDR_HC_CONTROL, 32'd0, 1'b0);

    wr("wr_hc_control", ADDR_HC_CONTROL, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    rd("rd_hc_control", ADDR_HC_CONTROL, 32'h8000_0001, 1'b0);
    check("out_hc_control", hwif_out.hc_control, 32'h8000_0001);

    wr("wr_cda", ADDR_CONTROLLER_DEVICE_ADDR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    rd("rd_cda", ADDR_CONTROLLER_DEVICE_ADDR, 32'h807F_0000, 1'b0);
    check("out_cda", hwif_out.controller_device_addr, 32'h807F_0000);

    rd("rd_caps", ADDR_HC_CAPABILITIES, 32'hA5A5_0F0F, 1'b0);
    rd("rd_present", ADDR_PRESENT_STATE, 32'h1234_5678, 1'b0);

    wr("wr_rstctl", ADDR_RESET_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    rd("rd_rstctl", ADDR_RESET_CONTROL, 32'h0000_003F, 1'b0);
    wr("wr_rstctl_hwclr", ADDR_RESET_CONTROL, 32'h0000_0015, 32'h0000_003F, 1'b0);
    rd("rd_rstctl_nochange", ADDR_RESET_CONTROL, 32'h0000_0015, 1'b0);
    hwif_in.soft_rst_clr = 1'b1;
    wr("wr_rstctl_race", ADDR_RESET_CONTROL, 32'h0000_0001, 32'h0000_0001, 1'b0);
    hwif_in.soft_rst_clr = 1'b0;
    rd("rd_rstctl_hw_wins", ADDR_RESET_CONTROL, 32'h0000_0014, 1'b0);

    wr("wr_sts_en", ADDR_INTR_STATUS_ENABLE, 32'h1, 32'hFFFF_FFFF, 1'b0);
    wr("wr_sig_en", ADDR_INTR_SIGNAL_ENABLE, 32'h1, 32'hFFFF_FFFF, 1'b0);
    check("intr_idle", {31'd0, hwif_out.intr}, 32'd0);
    hwif_in.intr_set = 32'h1;
    @(posedge clk); #1;
    hwif_in.intr_set = 32'h0;
    rd("rd_sts_set", ADDR_INTR_STATUS, 32'h1, 1'b0);
    check("intr_asserted", {31'd0, hwif_out.intr}, 32'd1);
    wr("w1c_sts", ADDR_INTR_STATUS, 32'h1, 32'hFFFF_FFFF, 1'b0);
    rd("rd_sts_cleared", ADDR_INTR_STATUS, 32'h0, 1'b0);
    check("intr_cleared", {31'd0, hwif_out.intr}, 32'd0);

    hwif_in.intr_set = 32'h1;
    wr("w1c_vs_set", ADDR_INTR_STATUS, 32'h1, 32'hFFFF_FFFF, 1'b0);
    hwif_in.intr_set = 32'h0;
    rd("rd_set_wins", ADDR_INTR_STATUS, 32'h1, 1'b0);
    wr("w1c_sts_all", ADDR_INTR_STATUS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    wr("wr_sts_en_0", ADDR_INTR_STATUS_ENABLE, 32'h0, 32'hFFFF_FFFF, 1'b0);
    wr("force_gated", ADDR_INTR_FORCE, 32'h2, 32'hFFFF_FFFF, 1'b0);
    rd("rd_sts_gated", ADDR_INTR_STATUS, 32'h0, 1'b0);
    wr("wr_sts_en_2", ADDR_INTR_STATUS_ENABLE, 32'h2, 32'hFFFF_FFFF, 1'b0);
    wr("force_en", ADDR_INTR_FORCE, 32'h2, 32'hFFFF_FFFF, 1'b0);
    rd("rd_sts_forced", ADDR_INTR_STATUS, 32'h2, 1'b0);
    rd("rd_force_wo", ADDR_INTR_FORCE, 32'h0, 1'b0);
    check("intr_unsignalled", {31'd0, hwif_out.intr}, 32'd0);

    rd("rd_unmapped", 8'h3C, 32'h0, 1'b1);
    rd("rd_hole", 8'h18, 32'h0, 1'b1);
    wr("wr_unmapped", 8'h3C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wr("wr_ro_version", ADDR_HC_VERSION, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    rd("rd_version_kept", ADDR_HC_VERSION, 32'h0000_0120, 1'b0);
    rd("rd_addr_low_bits", 8'h07, 32'h8000_0001, 1'b0);

    // Reset pulse away from any clock edge must clear state immediately.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_hc_control", hwif_out.hc_control, 32'd0);
    check("async_intr_status", hwif_out.intr_status, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd("post_rst_hc_control", ADDR_HC_CONTROL, 32'd0, 1'b0);
    rd("post_rst_cda", ADDR_CONTROLLER_DEVICE_ADDR, 32'd0, 1'b0);
    rd("post_rst_rstctl", ADDR_RESET_CONTROL, 32'd0, 1'b0);
    rd("post_rst_sts", ADDR_INTR_STATUS, 32'd0, 1'b0);
    rd("post_rst_sts_en", ADDR_INTR_STATUS_ENABLE, 32'd0, 1'b0);
    rd("post_rst_sig_en", ADDR_INTR_SIGNAL_ENABLE, 32'd0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
